controller_fifo_unstack: RTL

CONTROLLER_FIFO_UNSTACK -- requirements
Module: controller_fifo_unstack

---
 rtl/controller_pkg.sv | 14 +
 rtl/controller_fifo_ram.sv | 67 ++++++
 rtl/controller_fifo_unstack.sv | 121 ++++++++++++
 3 files changed

// File: rtl/controller_pkg.sv
// ---------------------------------------------------------------------------
// controller_pkg
// Shared defaults for the controller FIFO family (stack and unstack variants).
//   CTRL_FIFO_ABITS  : log2 of storage depth in items
//   CTRL_FIFO_DBITS  : width of one item
//   CTRL_FIFO_WR_PKT : items written per write (power of two, <= depth)
// ---------------------------------------------------------------------------
package controller_pkg;

    localparam int CTRL_FIFO_ABITS  = 4;
    localparam int CTRL_FIFO_DBITS  = 2;
    localparam int CTRL_FIFO_WR_PKT = 4;

endpackage

// File: rtl/controller_fifo_ram.sv
// ---------------------------------------------------------------------------
// controller_fifo_ram
// Storage for controller_fifo_unstack. Organised as rows of wr_pkt items so a
// whole write block lands in one row; reads fetch a row and select one item.
// Ports:
//   clk    : clock
//   we     : write enable for one wr_pkt-item block
//   waddr  : item address of the block (always a multiple of wr_pkt)
//   wdata  : block data, item 0 in the lowest slice
//   re     : read enable; rdata updates only when re=1, otherwise holds
//   raddr  : item address to read
//   rdata  : registered item read data
// Contents are not reset.
// ---------------------------------------------------------------------------
module controller_fifo_ram
    import controller_pkg::*;
#(
    parameter int abits  = CTRL_FIFO_ABITS,
    parameter int dbits  = CTRL_FIFO_DBITS,
    parameter int wr_pkt = CTRL_FIFO_WR_PKT
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [abits-1:0]        waddr,
    input  logic [dbits*wr_pkt-1:0] wdata,
    input  logic                    re,
    input  logic [abits-1:0]        raddr,
    output logic [dbits-1:0]        rdata
);

    localparam int pbits = $clog2(wr_pkt);
    localparam int obits = (pbits > 0) ? pbits : 1;
    localparam int rows  = (2 ** abits) / wr_pkt;
    localparam int rbits = (rows > 1) ? $clog2(rows) : 1;

    logic [dbits*wr_pkt-1:0] mem [rows];
    logic [dbits*wr_pkt-1:0] row_q;
    logic [obits-1:0]        off_q;
    logic [rbits-1:0]        wrow;
    logic [rbits-1:0]        rrow;
    logic [obits-1:0]        roff;
    logic [dbits-1:0]        row_items [wr_pkt];

    // Row index is the item address with the in-block offset dropped.
    assign wrow = rbits'(waddr >> pbits);
    assign rrow = rbits'(raddr >> pbits);
    assign roff = obits'(raddr & abits'(wr_pkt - 1));

    // Read-first row access; the offset is registered alongside the row so
    // the item select stays consistent with the fetched row.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wrow] <= wdata;
        end
        if (re) begin
            row_q <= mem[rrow];
            off_q <= roff;
        end
    end

    for (genvar gi = 0; gi < wr_pkt; gi++) begin : g_item
        assign row_items[gi] = row_q[gi*dbits +: dbits];
    end

    assign rdata = row_items[off_q];

endmodule

// File: rtl/controller_fifo_unstack.sv
// ---------------------------------------------------------------------------
// controller_fifo_unstack
// FIFO that accepts wr_pkt-item blocks and returns them one item at a time,
// lowest slice of each block first.
// Ports:
//   clk       : clock, all state changes on rising edge
//   reset_n   : asynchronous active-low reset
//   wr        : write one block (ignored while full)
//   rd        : read one item (ignored while empty)
//   din       : write block, slice [dbits-1:0] leaves first
//   dout      : last item read, registered, holds between reads
//   empty     : count == 0
//   full      : free space < wr_pkt
//   count     : items stored
//   overflow  : one-cycle pulse after a write attempted while full
//   underflow : one-cycle pulse after a read attempted while empty
// ---------------------------------------------------------------------------
module controller_fifo_unstack
    import controller_pkg::*;
#(
    parameter int abits  = CTRL_FIFO_ABITS,
    parameter int dbits  = CTRL_FIFO_DBITS,
    parameter int wr_pkt = CTRL_FIFO_WR_PKT
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    wr,
    input  logic                    rd,
    input  logic [dbits*wr_pkt-1:0] din,
    output logic [dbits-1:0]        dout,
    output logic                    empty,
    output logic                    full,
    output logic [abits:0]          count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int depth = 2 ** abits;
    // full when depth - count < wr_pkt, i.e. count >= depth - wr_pkt + 1
    localparam logic [abits:0]   full_at = (abits+1)'(depth - wr_pkt + 1);
    localparam logic [abits:0]   pkt_cnt = (abits+1)'(wr_pkt);
    // Truncation gives the modulo-depth step (0 when wr_pkt == depth).
    localparam logic [abits-1:0] pkt_ptr = abits'(wr_pkt);

    logic [abits-1:0] wptr_q, wptr_d;
    logic [abits-1:0] rptr_q, rptr_d;
    logic [abits:0]   count_q, count_d;
    logic             dout_valid_q, dout_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             wr_ok;
    logic             rd_ok;
    logic [dbits-1:0] ram_rdata;

    // Acceptance is judged purely from registered state, so a read in the
    // same cycle as the first write into an empty FIFO is rejected.
    assign empty = (count_q == '0);
    assign full  = (count_q >= full_at);
    assign wr_ok = wr && !full;
    assign rd_ok = rd && !empty;

    always_comb begin
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        count_d      = count_q;
        dout_valid_d = dout_valid_q;
        overflow_d   = wr && full;
        underflow_d  = rd && empty;

        if (wr_ok) begin
            wptr_d = wptr_q + pkt_ptr;
        end
        if (rd_ok) begin
            rptr_d       = rptr_q + 1'b1;
            dout_valid_d = 1'b1;
        end
        count_d = count_q + (wr_ok ? pkt_cnt : '0) - (rd_ok ? (abits+1)'(1) : '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            dout_valid_q <= dout_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    controller_fifo_ram #(
        .abits  (abits),
        .dbits  (dbits),
        .wr_pkt (wr_pkt)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wptr_q),
        .wdata (din),
        .re    (rd_ok),
        .raddr (rptr_q),
        .rdata (ram_rdata)
    );

    // The RAM read register cannot be reset, so dout is forced to zero until
    // the first accepted read after reset; afterwards the RAM register holds
    // the last popped item because it only loads on accepted reads.
    assign dout      = dout_valid_q ? ram_rdata : '0;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule
